// File: rtl/data_mem_copier.sv
// Data-RAM bus initiator: copies a block of words (src -> dst) or fills a block
// with a constant, one RAM access per cycle, all bus outputs registered.
module data_mem_copier #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Length,
  input  logic [DATA_W-1:0] FillValue,
  input  logic [DATA_W-1:0] MemRdData,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] MemWrData,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  WordCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    wc_q, wc_d;
  logic [LEN_W-1:0]    idx_inc;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  assign idx_inc = idx_q + LEN_W'(1);

  // State, operation registers and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      wc_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and operation bookkeeping; Start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d = Mode;
          src_d  = SrcAddr;
          dst_d  = DstAddr;
          len_d  = Length;
          fill_d = FillValue;
          idx_d  = '0;
          wc_d   = '0;
          if (Length == '0)  state_d = S_DONE;
          else if (Mode)     state_d = S_WRITE;
          else               state_d = S_READ;
        end
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        idx_d = idx_inc;
        wc_d  = wc_q + LEN_W'(1);
        if (idx_inc == len_q) state_d = S_DONE;
        else if (mode_q)      state_d = S_WRITE;
        else                  state_d = S_READ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs for the coming cycle, derived from the state being entered
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      S_READ: begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = src_d + ADDR_W'(idx_d);
      end
      S_WRITE: begin
        wr_d    = 1'b1;
        busy_d  = 1'b1;
        addr_d  = dst_d + ADDR_W'(idx_d);
        // The word read this cycle becomes the holding value for the write
        wdata_d = (state_q == S_READ) ? MemRdData : fill_d;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign DataAddress = addr_q;
  assign ReadMem     = rd_q;
  assign WriteMem    = wr_q;
  assign MemWrData   = wdata_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign WordCount   = wc_q;

endmodule

// File: tb/tb_data_mem_copier.sv
// Directed bench for data_mem_copier: RAM model plus a write scoreboard fed by
// a reference memory; every bus write is popped and compared as it happens.
module tb_data_mem_copier;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start, Mode;
  logic [15:0] SrcAddr, DstAddr, Length, FillValue, MemRdData;
  logic [15:0] DataAddress, MemWrData, WordCount;
  logic        ReadMem, WriteMem, Busy, Done;

  logic [15:0] ram [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        tb_we;
  logic [15:0] tb_addr, tb_data;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_copier dut (
    .clk(clk), .reset(reset), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
    .FillValue(FillValue), .MemRdData(MemRdData),
    .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .MemWrData(MemWrData), .Busy(Busy), .Done(Done), .WordCount(WordCount)
  );

  // RAM: combinational read, write on posedge; bench preload port when idle
  assign MemRdData = ReadMem ? ram[DataAddress] : 16'h0000;
  always @(posedge clk) begin
    if (WriteMem)   ram[DataAddress] <= MemWrData;
    else if (tb_we) ram[tb_addr]     <= tb_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge and score whatever the bus did this cycle
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (ReadMem) rd_cnt++;
    if (WriteMem) begin
      wr_cnt++;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {DataAddress, MemWrData}, e);
      end
    end
    if (ReadMem && WriteMem) chk("rd_wr_exclusive", 32'(ReadMem & WriteMem), 32'd0);
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    ref_mem[a] = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic run_op(input logic mode, input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input logic [15:0] fill,
                        input int exp_cyc, input bit start_mid);
    int n, rd0, wr0;
    logic [15:0] a, d;
    for (int i = 0; i < int'(len); i++) begin
      a = 16'(dst + 16'(i));
      d = mode ? fill : ref_mem[16'(src + 16'(i))];
      ref_mem[a] = d;
      exp_q.push_back({a, d});
    end
    rd0 = rd_cnt; wr0 = wr_cnt;
    Mode = mode; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fill;
    Start = 1'b1;
    step();
    Start = 1'b0;
    n = 1;
    if (len != 16'd0) chk("busy_first_cycle", 32'(Busy), 32'd1);
    while (Done !== 1'b1 && n < 300) begin
      if (start_mid && n == 2) begin
        Start = 1'b1; Mode = 1'b1; DstAddr = 16'h0070; Length = 16'd5;
      end else begin
        Start = 1'b0;
      end
      step();
      n++;
    end
    Start = 1'b0;
    chk("done_seen", 32'(Done), 32'd1);
    chk("done_latency", 32'(n), 32'(exp_cyc));
    chk("busy_in_done", 32'(Busy), 32'd0);
    chk("wordcount", 32'(WordCount), 32'(len));
    chk("read_count", 32'(rd_cnt - rd0), mode ? 32'd0 : 32'(len));
    chk("write_count", 32'(wr_cnt - wr0), 32'(len));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    step();
    chk("done_pulse_end", 32'(Done), 32'd0);
    chk("wordcount_hold", 32'(WordCount), 32'(len));
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Mode = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    step(); step();
    chk("rst_outputs", {DataAddress, 5'(0), ReadMem, WriteMem, Busy, Done, 8'(0)}, 32'd0);
    chk("rst_wdata_wc", {MemWrData, WordCount}, 32'd0);
    reset = 1'b0;
    step();

    // Preload copy sources and the reset-test region
    poke(16'h0020, 16'h0001); poke(16'h0021, 16'h0002); poke(16'h0022, 16'h0003);
    for (int i = 0; i < 4; i++) poke(16'(16'h0080 + i), 16'h0000);

    run_op(1'b1, 16'h0000, 16'h0010, 16'd4, 16'hBEEF, 5, 1'b0);
    for (int i = 0; i < 4; i++) chk("fill_ram", 32'(ram[16'(16'h0010 + i)]), 32'h0000BEEF);

    run_op(1'b0, 16'h0020, 16'h0040, 16'd3, 16'h0000, 7, 1'b0);
    for (int i = 0; i < 3; i++) chk("copy_ram", 32'(ram[16'(16'h0040 + i)]), 32'(i + 1));

    run_op(1'b1, 16'h0000, 16'h0200, 16'd0, 16'h1234, 1, 1'b0);

    run_op(1'b1, 16'h0000, 16'hFFFF, 16'd2, 16'h0055, 3, 1'b0);
    chk("wrap_ram_ffff", 32'(ram[16'hFFFF]), 32'h00000055);
    chk("wrap_ram_0000", 32'(ram[16'h0000]), 32'h00000055);

    run_op(1'b0, 16'h0020, 16'h0050, 16'd3, 16'h0000, 7, 1'b1);
    chk("mid_start_ram", 32'(ram[16'h0052]), 32'h00000003);
    chk("mid_start_nofill", 32'(ram[16'h0070]) == 32'h5, 32'd0);

    // Reset while the second of four fill words is on the bus
    Mode = 1'b1; DstAddr = 16'h0080; Length = 16'd4; FillValue = 16'hA5A5;
    for (int i = 0; i < 4; i++) exp_q.push_back({16'(16'h0080 + i), 16'hA5A5});
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_flags", {ReadMem, WriteMem, Busy, Done}, 32'd0);
    chk("midrst_addr_data", {DataAddress, MemWrData}, 32'd0);
    chk("midrst_wordcount", 32'(WordCount), 32'd0);
    exp_q.delete();
    step(); step();
    chk("midrst_word1", 32'(ram[16'h0080]), 32'h0000A5A5);
    chk("midrst_word2", 32'(ram[16'h0081]), 32'h00000000);
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) ref_mem[16'(16'h0080 + i)] = ram[16'(16'h0080 + i)];
    run_op(1'b1, 16'h0000, 16'h0090, 16'd2, 16'h0F0F, 3, 1'b0);
    chk("post_rst_ram", 32'(ram[16'h0091]), 32'h00000F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
